// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset CPU: PC, instruction ROM and register file.
// Fetch, decode, execute and write-back all complete in one clock cycle.

module PC (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q, pc_d;

  assign pc_d = pc_q + 32'd4;
  assign pc_o = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= '0;
    else if (en_i) pc_q <= pc_d;
  end
endmodule

module Instruction_Memory (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];

  // Load port is tied off at the top; contents are normally preloaded.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[wa_i] <= wd_i;
  end

  assign instr_o = memory[addr_i];
endmodule

module Registers (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) register[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : register[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : register[ra2_i];
endmodule

module single_cycle_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int NUM_REGS   = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rs_v, rt_v;
  logic [31:0] imm_sx;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        dec_we;
  logic        rf_we;
  logic        unused_pc;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};

  assign unused_pc = ^{pc[31:10], pc[1:0]};

  PC PC (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i),
    .pc_o  (pc)
  );

  Instruction_Memory Instruction_Memory (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .wa_i    (8'd0),
    .wd_i    (32'd0),
    .addr_i  (pc[9:2]),
    .instr_o (instr)
  );

  logic is_r, is_addi;
  assign is_r    = (op == 6'b000000);
  assign is_addi = (op == 6'b001000);

  always_comb begin
    wb_data = '0;
    wb_addr = rd;
    dec_we  = 1'b0;
    unique case (1'b1)
      is_addi: begin
        wb_addr = rt;
        wb_data = rs_v + imm_sx;
        dec_we  = 1'b1;
      end
      is_r && funct == 6'b100000: begin
        wb_data = rs_v + rt_v;
        dec_we  = 1'b1;
      end
      is_r && funct == 6'b100010: begin
        wb_data = rs_v - rt_v;
        dec_we  = 1'b1;
      end
      is_r && funct == 6'b100100: begin
        wb_data = rs_v & rt_v;
        dec_we  = 1'b1;
      end
      is_r && funct == 6'b100101: begin
        wb_data = rs_v | rt_v;
        dec_we  = 1'b1;
      end
      is_r && funct == 6'b011000: begin
        wb_data = rs_v * rt_v;
        dec_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset at the edge suppresses the write-back of the aborted instruction.
  assign rf_we = dec_we & start_i & ~rst_i;

  Registers Registers (
    .clk_i (clk_i),
    .we_i  (rf_we),
    .ra1_i (rs),
    .ra2_i (rt),
    .wa_i  (wb_addr),
    .wd_i  (wb_data),
    .rd1_o (rs_v),
    .rd2_o (rt_v)
  );
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu.
// Preloads ROM/regs hierarchically, steps the clock, checks PC and registers.

module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int checks = 0;
  int failures = 0;

  single_cycle_cpu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.Registers.register[i];
  endfunction

  initial begin
    logic [31:0] acc;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'h0;

    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", dut.pc, 32'd0);

    // Empty memory: PC counts, registers stay zero
    rst = 1'b0;
    start = 1'b1;
    step(1);
    chk("empty_pc4", dut.pc, 32'd4);
    step(2);
    chk("empty_pc12", dut.pc, 32'd12);
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    chk("empty_regs", acc, 32'd0);

    // Load program
    rst = 1'b1;
    dut.Instruction_Memory.memory[0]  = 32'h20080005;
    dut.Instruction_Memory.memory[1]  = 32'h2009FFFD;
    dut.Instruction_Memory.memory[2]  = 32'h01095020;
    dut.Instruction_Memory.memory[3]  = 32'h01095822;
    dut.Instruction_Memory.memory[4]  = 32'h20090003;
    dut.Instruction_Memory.memory[5]  = 32'h01096024;
    dut.Instruction_Memory.memory[6]  = 32'h01096825;
    dut.Instruction_Memory.memory[7]  = 32'h01097018;
    dut.Instruction_Memory.memory[8]  = 32'h01CC7820;
    dut.Instruction_Memory.memory[9]  = 32'h20000007;
    dut.Instruction_Memory.memory[10] = 32'hFC000000;
    dut.Instruction_Memory.memory[11] = 32'h00000000;
    dut.Instruction_Memory.memory[12] = 32'h01288822;
    dut.Instruction_Memory.memory[13] = 32'h02289018;
    dut.Instruction_Memory.memory[14] = 32'h20130009;
    dut.Instruction_Memory.memory[15] = 32'h20080064;
    step(1);
    chk("rst_pc", dut.pc, 32'd0);
    rst = 1'b0;

    step(2);
    chk("addi_r8", rf(8), 32'd5);
    chk("addi_r9", rf(9), 32'hFFFFFFFD);
    chk("pc8", dut.pc, 32'd8);
    step(2);
    chk("add_r10", rf(10), 32'd2);
    chk("sub_r11", rf(11), 32'd8);
    step(1);
    chk("addi_r9b", rf(9), 32'd3);
    step(3);
    chk("and_r12", rf(12), 32'd1);
    chk("or_r13", rf(13), 32'd7);
    chk("mul_r14", rf(14), 32'd15);
    step(1);
    chk("raw_r15", rf(15), 32'd16);
    step(1);
    chk("r0_zero", rf(0), 32'd0);
    step(2);
    chk("nop_r8", rf(8), 32'd5);
    chk("nop_r13", rf(13), 32'd7);
    chk("nop_r15", rf(15), 32'd16);
    chk("nop_r0", rf(0), 32'd0);
    step(2);
    chk("sub_neg_r17", rf(17), 32'hFFFFFFFE);
    chk("mul_neg_r18", rf(18), 32'hFFFFFFF6);
    chk("pc56", dut.pc, 32'd56);

    // Stall: PC and registers frozen
    start = 1'b0;
    step(3);
    chk("stall_pc", dut.pc, 32'd56);
    chk("stall_r19", rf(19), 32'd0);
    start = 1'b1;
    step(1);
    chk("resume_r19", rf(19), 32'd9);
    chk("resume_pc", dut.pc, 32'd60);

    // Mid-run reset: async PC clear, no writes, regs kept
    dut.Instruction_Memory.memory[0] = 32'h20140001;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", dut.pc, 32'd0);
    step(2);
    chk("rst_no_wr_r20", rf(20), 32'd0);
    chk("rst_no_wr_r8", rf(8), 32'd5);
    chk("rst_keep_r19", rf(19), 32'd9);
    rst = 1'b0;
    step(1);
    chk("post_rst_r20", rf(20), 32'd1);
    chk("post_rst_pc", dut.pc, 32'd4);

    // Wrap: only mem[0] increments r21
    rst = 1'b1;
    for (int i = 1; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    dut.Instruction_Memory.memory[0] = 32'h22B50001;
    step(1);
    rst = 1'b0;
    step(256);
    chk("wrap_pc", dut.pc, 32'd1024);
    chk("wrap_r21a", rf(21), 32'd1);
    step(1);
    chk("wrap_r21b", rf(21), 32'd2);
    chk("wrap_pc2", dut.pc, 32'd1028);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
